// File: rtl/l1_core_request_buffer.sv
// l1_core_request_buffer
// In-order request FIFO sitting between the core pipeline and the L1 core port.
// Core requests are buffered up to DEPTH deep and issued to the L1 one at a time.
// Each entry is retired when the L1 completes it. Read data comes back to the
// core as a one-cycle registered response. Writes get no response.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready depends only on registered occupancy, so the core can hold
// req_valid high until it sees the transfer. A full buffer never accepts a new
// request, even when an entry is retired on that same edge.
module l1_core_request_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int DEPTH        = 4,
  localparam int PTR_BITS    = $clog2(DEPTH),
  localparam int BE_BITS     = DATA_WIDTH / 8
) (
  input  logic                    clock,
  input  logic                    reset,
  // core request side
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [BE_BITS-1:0]      req_byte_en,
  input  logic [ADDRESS_BITS-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]   req_data,
  // core response side
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic [ADDRESS_BITS-1:0] resp_address,
  output logic [PTR_BITS:0]       occupancy,
  // L1 core port
  output logic                    l1_read,
  output logic                    l1_write,
  output logic [BE_BITS-1:0]      l1_w_byte_en,
  output logic [ADDRESS_BITS-1:0] l1_address,
  output logic [DATA_WIDTH-1:0]   l1_data_in,
  input  logic                    l1_ready,
  input  logic                    l1_valid,
  input  logic [DATA_WIDTH-1:0]   l1_data_out,
  input  logic [ADDRESS_BITS-1:0] l1_out_address,
  // issue FSM state, for observation
  output logic [1:0]              debug_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    WAIT_WR = 2'd3
  } state_t;

  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

  state_t                    state;
  logic [PTR_BITS-1:0]       wr_ptr;
  logic [PTR_BITS-1:0]       rd_ptr;
  logic                      push;
  logic                      pop;

  logic                      mem_write   [DEPTH];
  logic [BE_BITS-1:0]        mem_byte_en [DEPTH];
  logic [ADDRESS_BITS-1:0]   mem_address [DEPTH];
  logic [DATA_WIDTH-1:0]     mem_data    [DEPTH];

  logic                      head_write;
  logic [BE_BITS-1:0]        head_byte_en;
  logic [ADDRESS_BITS-1:0]   head_address;
  logic [DATA_WIDTH-1:0]     head_data;

  assign req_ready   = (occupancy != FULL_COUNT);
  assign push        = reset && req_valid && req_ready;
  // The head entry retires on read data return or on the first idle L1 cycle after a write.
  assign pop         = ((state == WAIT_RD) && l1_valid) || ((state == WAIT_WR) && l1_ready);
  assign debug_state = state;

  assign head_write   = mem_write[rd_ptr];
  assign head_byte_en = mem_byte_en[rd_ptr];
  assign head_address = mem_address[rd_ptr];
  assign head_data    = mem_data[rd_ptr];

  // Entry storage: written at the tail on an accepted request; no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_write[wr_ptr]   <= req_write;
      mem_byte_en[wr_ptr] <= req_byte_en;
      mem_address[wr_ptr] <= req_address;
      mem_data[wr_ptr]    <= req_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); occupancy holds when push and pop coincide.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (PTR_BITS+1)'(1);
        2'b01:   occupancy <= occupancy - (PTR_BITS+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Issue FSM: latch the head onto the L1 bus, strobe for one cycle, wait for completion.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      l1_read      <= 1'b0;
      l1_write     <= 1'b0;
      l1_w_byte_en <= '0;
      l1_address   <= '0;
      l1_data_in   <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_address <= '0;
    end else begin
      l1_read    <= 1'b0;
      l1_write   <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if ((occupancy != '0) && l1_ready) begin
            state        <= ISSUE;
            l1_read      <= !head_write;
            l1_write     <= head_write;
            l1_w_byte_en <= head_byte_en;
            l1_address   <= head_address;
            l1_data_in   <= head_data;
          end
        end
        ISSUE: begin
          state <= l1_write ? WAIT_WR : WAIT_RD;
        end
        WAIT_RD: begin
          if (l1_valid) begin
            resp_valid   <= 1'b1;
            resp_data    <= l1_data_out;
            resp_address <= l1_out_address;
            state        <= IDLE;
          end
        end
        WAIT_WR: begin
          if (l1_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_core_request_buffer.sv
// Directed bench for l1_core_request_buffer with a behavioural L1 model
// (byte-addressed word memory with programmable latency) and scoreboards for
// issue order and read responses.
module tb_l1_core_request_buffer;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [3:0]  req_byte_en = 4'h0;
  logic [31:0] req_address = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] resp_address;
  logic [2:0]  occupancy;
  logic        l1_read;
  logic        l1_write;
  logic [3:0]  l1_w_byte_en;
  logic [31:0] l1_address;
  logic [31:0] l1_data_in;
  logic        l1_ready = 1'b1;
  logic        l1_valid = 1'b0;
  logic [31:0] l1_data_out = 32'h0;
  logic [31:0] l1_out_address = 32'h0;
  logic [1:0]  debug_state;

  l1_core_request_buffer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte_en(req_byte_en), .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_address(resp_address),
    .occupancy(occupancy),
    .l1_read(l1_read), .l1_write(l1_write), .l1_w_byte_en(l1_w_byte_en),
    .l1_address(l1_address), .l1_data_in(l1_data_in),
    .l1_ready(l1_ready), .l1_valid(l1_valid), .l1_data_out(l1_data_out),
    .l1_out_address(l1_out_address), .debug_state(debug_state)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  int cycle_cnt = 0;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  logic [63:0] exp_q[$];    // {address, data} of expected read responses
  logic [68:0] issue_q[$];  // {write, byte_en, address, data} in expected issue order
  int          strobe_log[$];

  logic [31:0] l1_mem  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int          rd_lat = 1;
  int          wr_lat = 1;
  int          busy = 0;
  logic        l1_hold = 1'b0;
  logic        pend_rd = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          strobe_cnt = 0;
  int          resp_cnt = 0;
  int          last_strobe_cycle = 0;
  int          last_resp_cycle = 0;
  int          last_push_cycle = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] l1_rd(input logic [31:0] a);
    if (l1_mem.exists(a)) return l1_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  // L1 model: samples strobes on the falling edge, goes busy for the programmed latency.
  always @(negedge clock) begin
    l1_valid = 1'b0;
    if (l1_read || l1_write) begin
      strobe_cnt++;
      last_strobe_cycle = cycle_cnt;
      strobe_log.push_back(cycle_cnt);
      check("strobe_exclusive", {l1_read, l1_write} != 2'b11, 1);
      check("issue_when_ready", l1_ready, 1);
      check("issue_expected", issue_q.size() > 0, 1);
      if (issue_q.size() > 0)
        check("issue_order", {l1_write, l1_w_byte_en, l1_address, l1_data_in}, issue_q.pop_front());
      if (l1_write) l1_mem[l1_address] = merge(l1_rd(l1_address), l1_data_in, l1_w_byte_en);
      pend_rd   = l1_read;
      pend_addr = l1_address;
      busy      = l1_write ? wr_lat : rd_lat;
      l1_ready  = 1'b0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0 && pend_rd) begin
        l1_valid       = 1'b1;
        l1_data_out    = l1_rd(pend_addr);
        l1_out_address = pend_addr;
      end
    end
    if (busy == 0) l1_ready = !l1_hold;
  end

  // Response scoreboard
  always @(negedge clock) begin
    if (resp_valid) begin
      resp_cnt++;
      last_resp_cycle = cycle_cnt;
      check("resp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("resp_addr_data", {resp_address, resp_data}, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // driver: present a request, wait (bounded) for acceptance, record expectations
  task automatic push_req(input logic w, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_byte_en = be; req_address = a; req_data = d;
    while (!req_ready && n < 200) begin
      tick(1);
      n++;
    end
    check("push_ready", req_ready, 1);
    @(posedge clock);
    issue_q.push_back({w, be, a, d});
    if (w) ref_mem[a] = merge(ref_rd(a), d, be);
    else   exp_q.push_back({a, ref_rd(a)});
    #1;
    last_push_cycle = cycle_cnt;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((occupancy != 0 || exp_q.size() != 0 || issue_q.size() != 0 ||
            debug_state != ST_IDLE) && n < 300) begin
      tick(1);
      n++;
    end
    check({tag, "_occ"}, occupancy, 0);
    check({tag, "_queues"}, exp_q.size() + issue_q.size(), 0);
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, n, gap, wcyc;
    logic w;

    // 1: reset held with a request presented
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h40; req_byte_en = 4'hF;
    repeat (2) @(posedge clock);
    #1;
    check("reset_ready", req_ready, 1);
    check("reset_occ", occupancy, 0);
    check("reset_strobes", {resp_valid, l1_read, l1_write}, 0);
    check("reset_l1_bus", {l1_w_byte_en, l1_address, l1_data_in}, 0);
    check("reset_resp_bus", {resp_address, resp_data}, 0);
    req_valid = 1'b0;
    reset = 1'b1;
    tick(4);
    check("reset_nothing_stored", occupancy, 0);
    check("reset_no_issue", strobe_cnt, 0);

    // 2: single read, data returned 3 cycles after the strobe
    rd_lat = 3;
    l1_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    s0 = strobe_cnt; r0 = resp_cnt;
    push_req(1'b0, 4'hF, 32'h100, 32'h0);
    n = 0;
    while (resp_cnt == r0 && n < 50) begin tick(1); n++; end
    tick(3);
    check("rd_resp_count", resp_cnt - r0, 1);
    check("rd_single_strobe", strobe_cnt - s0, 1);
    check("rd_issue_latency", last_strobe_cycle - last_push_cycle, 1);
    check("rd_resp_latency", last_resp_cycle - last_push_cycle, 5);
    drain("rd");

    // 3: fill with L1 stalled, reject a fifth, then release and drain in order
    rd_lat = 1; wr_lat = 2;
    l1_hold = 1'b1;
    tick(1);
    s0 = strobe_cnt;
    push_req(1'b1, 4'hF, 32'h300, 32'hCAFE_0001);
    push_req(1'b0, 4'hF, 32'h304, 32'h0);
    push_req(1'b0, 4'hF, 32'h300, 32'h0);
    push_req(1'b1, 4'hC, 32'h308, 32'h7788_99AA);
    check("full_occ", occupancy, 4);
    check("full_not_ready", req_ready, 0);
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h3FC;
    tick(3);
    check("full_fifth_rejected", occupancy, 4);
    req_valid = 1'b0;
    l1_hold = 1'b0;
    drain("full");
    check("full_issue_count", strobe_cnt - s0, 4);

    // 4: partial write then read of the same word
    rd_lat = 2; wr_lat = 3;
    strobe_log.delete();
    push_req(1'b1, 4'b0011, 32'h200, 32'h1234_5678);
    push_req(1'b0, 4'hF, 32'h200, 32'h0);
    drain("wr_rd");
    check("wr_rd_strobes", strobe_log.size(), 2);
    if (strobe_log.size() == 2) begin
      gap = strobe_log[1] - strobe_log[0];
      check("wr_rd_gap", gap, 5);
    end

    // 5: full buffer, push presented on the pop edge, then push+pop at occupancy 3
    rd_lat = 1;
    l1_hold = 1'b1;
    tick(1);
    push_req(1'b0, 4'hF, 32'h400, 32'h0);
    push_req(1'b0, 4'hF, 32'h404, 32'h0);
    push_req(1'b0, 4'hF, 32'h408, 32'h0);
    push_req(1'b0, 4'hF, 32'h40C, 32'h0);
    check("pp_full", occupancy, 4);
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h500;
    req_byte_en = 4'hF; req_data = 32'h5555_AAAA;
    l1_hold = 1'b0;
    n = 0;
    while (occupancy == 4 && n < 50) begin tick(1); n++; end
    req_valid = 1'b0;
    check("pp_full_pop_push_rejected", occupancy, 3);
    n = 0;
    while (!(debug_state == ST_WAIT_RD && occupancy == 3) && n < 50) begin tick(1); n++; end
    check("pp_wait_rd_reached", debug_state, ST_WAIT_RD);
    push_req(1'b1, 4'hF, 32'h500, 32'h5555_AAAA);
    check("pp_push_pop_hold", occupancy, 3);
    drain("pp");

    // 6: reset while waiting on read data
    rd_lat = 8;
    s0 = strobe_cnt;
    push_req(1'b0, 4'hF, 32'h600, 32'h0);
    n = 0;
    while (strobe_cnt == s0 && n < 50) begin tick(1); n++; end
    tick(2);
    check("rst_in_wait_rd", debug_state, ST_WAIT_RD);
    reset = 1'b0;
    tick(2);
    exp_q.delete();
    issue_q.delete();
    reset = 1'b1;
    r0 = resp_cnt;
    tick(12);
    check("rst_no_resp", resp_cnt - r0, 0);
    check("rst_occ", occupancy, 0);
    check("rst_idle", debug_state, ST_IDLE);

    // 7: short random mix
    rd_lat = $urandom_range(1, 4);
    wr_lat = $urandom_range(1, 4);
    for (int i = 0; i < 12; i++) begin
      w = 1'($urandom_range(0, 1));
      push_req(w, 4'($urandom_range(1, 15)), 32'h700 + 32'(4 * $urandom_range(0, 7)), $urandom);
    end
    drain("rand");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
